// File: rtl/quad_encoder_gen.sv
// Quadrature encoder emulator: turns step commands into Gray-coded A/B edges,
// an index pulse at position 0, and a wrapped shaft position.
module quad_encoder_gen #(
   parameter int CNT_W          = 16,
   parameter int DWELL_W        = 16,
   parameter int COUNTS_PER_REV = 80,
   parameter int POS_W          = 7
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic               cmd_dir,
   input  logic [CNT_W-1:0]   cmd_count,
   input  logic [DWELL_W-1:0] cmd_dwell,
   input  logic               abort,
   output logic               a,
   output logic               b,
   output logic               index,
   output logic [POS_W-1:0]   position,
   output logic               busy,
   output logic               done
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [POS_W-1:0] POS_LAST = POS_W'(COUNTS_PER_REV - 1);

   logic [1:0]         state;
   logic [1:0]         phase;
   logic               dir_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [DWELL_W-1:0] dwell_q;
   logic [DWELL_W-1:0] timer;

   logic [DWELL_W-1:0] dwell_eff;
   logic [1:0]         phase_nxt;
   logic [POS_W-1:0]   pos_nxt;

   assign dwell_eff = (cmd_dwell == '0) ? DWELL_W'(1) : cmd_dwell;

   always_comb begin
      phase_nxt = dir_q ? phase + 2'd1 : phase - 2'd1;
      pos_nxt   = position;
      if (dir_q)
         pos_nxt = (position == POS_LAST) ? '0 : position + POS_W'(1);
      else
         pos_nxt = (position == '0) ? POS_LAST : position - POS_W'(1);
   end

   assign cmd_ready = (state != RUN);
   assign busy      = (state == RUN);
   assign done      = (state == DONE);

   // RUN always ends with a cycle at cnt_q==0 before DONE, so done lands one
   // cycle after the last edge, after an abort, or after a zero-count accept.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         phase    <= 2'd0;
         position <= '0;
         a        <= 1'b0;
         b        <= 1'b0;
         index    <= 1'b1;
         dir_q    <= 1'b0;
         cnt_q    <= '0;
         dwell_q  <= DWELL_W'(1);
         timer    <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               state <= IDLE;
               if (cmd_valid) begin
                  dir_q   <= cmd_dir;
                  cnt_q   <= cmd_count;
                  dwell_q <= dwell_eff;
                  timer   <= dwell_eff;
                  state   <= RUN;
               end
            end
            RUN: begin
               if (cnt_q == '0) begin
                  state <= DONE;
               end else if (abort) begin
                  cnt_q <= '0;
               end else if (timer == DWELL_W'(1)) begin
                  // (a,b) = 00,10,11,01 for phase 0..3
                  phase    <= phase_nxt;
                  a        <= phase_nxt[1] ^ phase_nxt[0];
                  b        <= phase_nxt[1];
                  position <= pos_nxt;
                  index    <= (pos_nxt == '0);
                  cnt_q    <= cnt_q - CNT_W'(1);
                  timer    <= dwell_q;
               end else begin
                  timer <= timer - DWELL_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
